unidade_controle_jogo_param: RTL and testbench

Parametrised successor control unit for the memory-sequence game. It integrates the address, round, error and timer counters that previously lived in the datapath, adds a selectable play mode (classic / strict / newest-only) and a per-round error limit, and drives the score phase that walks the error memory. It sits between the button/edge-detect logic and the sequence ROM, the error memory and the score register.

---
 rtl/unidade_controle_jogo_param_pkg.sv | 37 +++
 rtl/unidade_controle_jogo_param_if.sv | 40 ++++
 rtl/unidade_controle_jogo_param_contador.sv | 27 ++
 rtl/unidade_controle_jogo_param.sv | 224 ++++++++++++++++++++++
 tb/tb_unidade_controle_jogo_param.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/unidade_controle_jogo_param_pkg.sv
// rtl/unidade_controle_jogo_param_pkg.sv - shared state codes, play modes and width helper
// State codes match db_estado so the debug display needs no translation.
package unidade_controle_jogo_param_pkg;

  typedef logic [4:0] estado_t;

  localparam estado_t INICIAL     = 5'h00;
  localparam estado_t PREPARACAO  = 5'h01;
  localparam estado_t PROX_RODADA = 5'h02;
  localparam estado_t ESPERA      = 5'h03;
  localparam estado_t REGISTRA    = 5'h04;
  localparam estado_t COMPARA     = 5'h05;
  localparam estado_t PROXIMO     = 5'h06;
  localparam estado_t MOSTRA      = 5'h07;
  localparam estado_t APAGA       = 5'h08;
  localparam estado_t FIM_ACERTOU = 5'h0A;
  localparam estado_t FIM_RODADA  = 5'h0B;
  localparam estado_t PREP_E      = 5'h0C;
  localparam estado_t FIM_TIMEOUT = 5'h0D;
  localparam estado_t ERROU       = 5'h0E;
  localparam estado_t FIM_ERROU   = 5'h0F;
  localparam estado_t CALC        = 5'h10;
  localparam estado_t SALVA       = 5'h11;
  localparam estado_t PROX_POS    = 5'h12;
  localparam estado_t PREP_FIM    = 5'h13;
  localparam estado_t PAUSA       = 5'h14;

  localparam logic [1:0] MODO_CLASSICO = 2'b00;
  localparam logic [1:0] MODO_ESTRITO  = 2'b01;
  localparam logic [1:0] MODO_ULTIMO   = 2'b10;

  // Counter width for a terminal count of n; a 1-cycle phase still needs one bit.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_param_if.sv
// rtl/unidade_controle_jogo_param_if.sv - control unit bus towards buttons, ROM, error memory and score
// master = surrounding datapath/player, slave = control unit.
interface unidade_controle_jogo_param_if #(
  parameter int ADDR_W = 4,
  parameter int ERR_W  = 3
);
  logic              jogar;
  logic [1:0]        modo;
  logic              botoesIgualMemoria;
  logic              jogada;
  logic [ADDR_W-1:0] endereco;
  logic [ADDR_W-1:0] rodada;
  logic [ERR_W-1:0]  erros_rodada;
  logic              registraR;
  logic              mostraJ;
  logic              mostraB;
  logic              regErro;
  logic              zeraPontos;
  logic              regPontos;
  logic              mostraPontos;
  logic              serrou;
  logic              acertou;
  logic              db_timeout;
  logic              pronto;
  logic [4:0]        db_estado;

  modport master (
    output jogar, modo, botoesIgualMemoria, jogada,
    input  endereco, rodada, erros_rodada,
    input  registraR, mostraJ, mostraB, regErro, zeraPontos, regPontos, mostraPontos,
    input  serrou, acertou, db_timeout, pronto, db_estado
  );

  modport slave (
    input  jogar, modo, botoesIgualMemoria, jogada,
    output endereco, rodada, erros_rodada,
    output registraR, mostraJ, mostraB, regErro, zeraPontos, regPontos, mostraPontos,
    output serrou, acertou, db_timeout, pronto, db_estado
  );
endinterface

// File: rtl/unidade_controle_jogo_param_contador.sv
// rtl/unidade_controle_jogo_param_contador.sv - generic up counter with clear, load and enable
// Priority: clear, then load, then count.
module contador_param #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         carrega,
  input  logic [W-1:0] valor,
  input  logic         conta,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (carrega) begin
      q <= valor;
    end else if (conta) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/unidade_controle_jogo_param.sv
// rtl/unidade_controle_jogo_param.sv - memory-sequence game control unit with integrated counters
// Moore FSM with play modes, per-round error limit, play timeout and score walk over the error memory.
module unidade_controle_jogo_param
  import unidade_controle_jogo_param_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int N_RODADAS = 16,
  parameter int TIMEOUT   = 5000,
  parameter int T_LED     = 1000,
  parameter int ERR_W     = 3,
  parameter int MAX_ERROS = 3
) (
  input logic clock,
  input logic reset,
  unidade_controle_jogo_param_if.slave bus
);

  localparam int TW = largura(TIMEOUT);
  localparam int LW = largura(T_LED);
  localparam logic [ADDR_W-1:0] ULTIMA_RODADA = ADDR_W'(N_RODADAS - 1);
  localparam logic [TW-1:0]     T_FIM         = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0]     T2_FIM        = LW'(T_LED - 1);
  localparam logic [ERR_W-1:0]  ERROS_SAT     = '1;

  estado_t           estado, proxEstado;
  logic [1:0]        modoReg;
  logic [ADDR_W-1:0] endereco, rodada, recarga;
  logic [ERR_W-1:0]  erros;
  logic [TW-1:0]     t;
  logic [LW-1:0]     t2;

  logic zeraEnd, carregaEnd, contaEnd;
  logic zeraRod, contaRod;
  logic zeraErr, contaErr;
  logic zeraT, contaT;
  logic zeraT2, contaT2;

  logic fimT, fimT2, ultimoEnd, limiteErros;

  assign fimT        = (t == T_FIM);
  assign fimT2       = (t2 == T2_FIM);
  assign ultimoEnd   = (endereco == rodada);
  assign limiteErros = ((int'(erros) + 1) >= MAX_ERROS);

  // Replay start: newest-only mode shows only the current round's element; PROX_RODADA
  // already points at the round being entered.
  assign recarga = (modoReg != MODO_ULTIMO) ? '0 :
                   (estado == PROX_RODADA)  ? rodada + 1'b1 : rodada;

  contador_param #(.W(ADDR_W)) u_endereco (
    .clock(clock), .reset(reset), .zera(zeraEnd), .carrega(carregaEnd),
    .valor(recarga), .conta(contaEnd), .q(endereco)
  );

  contador_param #(.W(ADDR_W)) u_rodada (
    .clock(clock), .reset(reset), .zera(zeraRod), .carrega(1'b0),
    .valor('0), .conta(contaRod), .q(rodada)
  );

  contador_param #(.W(ERR_W)) u_erros (
    .clock(clock), .reset(reset), .zera(zeraErr), .carrega(1'b0),
    .valor('0), .conta(contaErr), .q(erros)
  );

  contador_param #(.W(TW)) u_timer (
    .clock(clock), .reset(reset), .zera(zeraT), .carrega(1'b0),
    .valor('0), .conta(contaT), .q(t)
  );

  contador_param #(.W(LW)) u_timer_led (
    .clock(clock), .reset(reset), .zera(zeraT2), .carrega(1'b0),
    .valor('0), .conta(contaT2), .q(t2)
  );

  // Mode 11 is folded into classic at latch time so later decisions see only three modes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      modoReg <= MODO_CLASSICO;
    end else if (estado == PREPARACAO) begin
      modoReg <= (bus.modo == 2'b11) ? MODO_CLASSICO : bus.modo;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proxEstado;
    end
  end

  always_comb begin
    proxEstado = INICIAL;
    case (estado)
      INICIAL:     proxEstado = bus.jogar ? PREPARACAO : INICIAL;
      PREPARACAO:  proxEstado = MOSTRA;
      MOSTRA:      proxEstado = fimT2 ? APAGA : MOSTRA;
      APAGA:       proxEstado = !fimT2 ? APAGA : (ultimoEnd ? PREP_E : MOSTRA);
      PREP_E:      proxEstado = ESPERA;
      ESPERA:      proxEstado = fimT ? FIM_TIMEOUT : (bus.jogada ? REGISTRA : ESPERA);
      REGISTRA:    proxEstado = COMPARA;
      COMPARA:     proxEstado = !bus.botoesIgualMemoria ? ERROU :
                                (ultimoEnd ? FIM_RODADA : PROXIMO);
      PROXIMO:     proxEstado = ESPERA;
      ERROU:       proxEstado = ((modoReg == MODO_ESTRITO) ||
                                 ((modoReg == MODO_CLASSICO) && limiteErros)) ? FIM_ERROU : MOSTRA;
      FIM_RODADA:  proxEstado = PAUSA;
      PAUSA:       proxEstado = !fimT2 ? PAUSA :
                                ((rodada == ULTIMA_RODADA) ? PREP_FIM : PROX_RODADA);
      PROX_RODADA: proxEstado = MOSTRA;
      PREP_FIM:    proxEstado = CALC;
      CALC:        proxEstado = SALVA;
      SALVA:       proxEstado = (endereco == ULTIMA_RODADA) ? FIM_ACERTOU : PROX_POS;
      PROX_POS:    proxEstado = CALC;
      FIM_ACERTOU: proxEstado = bus.jogar ? PREPARACAO : FIM_ACERTOU;
      FIM_TIMEOUT: proxEstado = bus.jogar ? PREPARACAO : FIM_TIMEOUT;
      FIM_ERROU:   proxEstado = bus.jogar ? PREPARACAO : FIM_ERROU;
      default:     proxEstado = INICIAL;
    endcase
  end

  // Strobes and counter controls; timers are held at zero whenever their phase is inactive.
  always_comb begin
    bus.registraR    = 1'b0;
    bus.mostraJ      = 1'b0;
    bus.mostraB      = 1'b0;
    bus.regErro      = 1'b0;
    bus.zeraPontos   = 1'b0;
    bus.regPontos    = 1'b0;
    bus.mostraPontos = 1'b0;
    bus.serrou       = 1'b0;
    bus.acertou      = 1'b0;
    bus.db_timeout   = 1'b0;
    bus.pronto       = 1'b0;
    zeraEnd    = 1'b0;
    carregaEnd = 1'b0;
    contaEnd   = 1'b0;
    zeraRod    = 1'b0;
    contaRod   = 1'b0;
    zeraErr    = 1'b0;
    contaErr   = 1'b0;
    zeraT      = 1'b1;
    contaT     = 1'b0;
    zeraT2     = 1'b1;
    contaT2    = 1'b0;
    case (estado)
      PREPARACAO: begin
        zeraEnd = 1'b1;
        zeraRod = 1'b1;
        zeraErr = 1'b1;
      end
      MOSTRA: begin
        bus.mostraJ = 1'b1;
        zeraT2      = fimT2;
        contaT2     = 1'b1;
      end
      APAGA: begin
        zeraT2   = fimT2;
        contaT2  = 1'b1;
        contaEnd = fimT2 && !ultimoEnd;
      end
      PREP_E:   zeraEnd = 1'b1;
      ESPERA: begin
        bus.mostraB = 1'b1;
        zeraT       = 1'b0;
        contaT      = 1'b1;
      end
      REGISTRA: bus.registraR = 1'b1;
      PROXIMO:  contaEnd = 1'b1;
      ERROU: begin
        bus.serrou       = 1'b1;
        bus.mostraPontos = 1'b1;
        contaErr         = (erros != ERROS_SAT);
        carregaEnd       = 1'b1;
      end
      FIM_RODADA: bus.regErro = 1'b1;
      PAUSA: begin
        zeraT2  = fimT2;
        contaT2 = 1'b1;
      end
      PROX_RODADA: begin
        contaRod   = 1'b1;
        zeraErr    = 1'b1;
        carregaEnd = 1'b1;
      end
      PREP_FIM: begin
        bus.zeraPontos   = 1'b1;
        bus.mostraPontos = 1'b1;
        zeraEnd          = 1'b1;
      end
      CALC: bus.mostraPontos = 1'b1;
      SALVA: begin
        bus.regPontos    = 1'b1;
        bus.mostraPontos = 1'b1;
      end
      PROX_POS: begin
        bus.mostraPontos = 1'b1;
        contaEnd         = 1'b1;
      end
      FIM_ACERTOU: begin
        bus.acertou      = 1'b1;
        bus.pronto       = 1'b1;
        bus.mostraPontos = 1'b1;
      end
      FIM_TIMEOUT: begin
        bus.db_timeout   = 1'b1;
        bus.pronto       = 1'b1;
        bus.mostraPontos = 1'b1;
      end
      FIM_ERROU: begin
        bus.serrou       = 1'b1;
        bus.pronto       = 1'b1;
        bus.mostraPontos = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.endereco     = endereco;
  assign bus.rodada       = rodada;
  assign bus.erros_rodada = erros;
  assign bus.db_estado    = estado;

endmodule

// File: tb/tb_unidade_controle_jogo_param.sv
// tb/tb_unidade_controle_jogo_param.sv - randomized self-checking bench for the game control unit
// A player model follows a per-round error plan; expected event traces come from the game rules.
module tb_unidade_controle_jogo_param;

  localparam int ADDR_W = 2, N_RODADAS = 3, TIMEOUT = 8, T_LED = 2, ERR_W = 3, MAX_ERROS = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  unidade_controle_jogo_param_if #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) bus ();

  unidade_controle_jogo_param #(
    .ADDR_W(ADDR_W), .N_RODADAS(N_RODADAS), .TIMEOUT(TIMEOUT),
    .T_LED(T_LED), .ERR_W(ERR_W), .MAX_ERROS(MAX_ERROS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int nTests = 0;
  int nFail  = 0;

  int errs[N_RODADAS];
  int errPos[N_RODADAS][4];

  int expMostra[$], expEspera[$], expRegErro[$], expPontos[$], expErrState[$], expErrCount[$];
  int obsMostra[$], obsEspera[$], obsRegErro[$], obsPontos[$];
  int expFim;

  bit   gravando = 1'b0;
  logic prevJ = 1'b0, prevB = 1'b0;

  always @(negedge clock) begin
    if (gravando) begin
      if (bus.mostraJ && !prevJ) obsMostra.push_back(int'(bus.endereco));
      if (bus.mostraB && !prevB) obsEspera.push_back(int'(bus.endereco));
      if (bus.regErro) obsRegErro.push_back(int'(bus.rodada) * 16 + int'(bus.erros_rodada));
      if (bus.regPontos) obsPontos.push_back(int'(bus.endereco));
    end
    prevJ <= bus.mostraJ;
    prevB <= bus.mostraB;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, nTests=%0d", nTests);
    $fatal(1, "watchdog");
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp)
      else begin
        nFail++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic comparaFila(input string tag, input int obs[$], input int exp[$]);
    verifica({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < obs.size() && i < exp.size(); i++)
      verifica(tag, obs[i], exp[i]);
  endtask

  function automatic logic condicao(input int sel);
    case (sel)
      0:       return bus.mostraB;
      1:       return bus.serrou;
      2:       return bus.pronto;
      3:       return bus.mostraJ && (bus.rodada == 2'd1);
      default: return bus.mostraJ;
    endcase
  endfunction

  task automatic esperaAte(input int sel, input int limite, input string tag, output bit ok);
    int n = 0;
    while (!condicao(sel) && n < limite) begin
      @(negedge clock);
      n++;
    end
    ok = condicao(sel);
    verifica({"wait_", tag}, ok, 1);
  endtask

  function automatic logic [10:0] saidas();
    return {bus.registraR, bus.mostraJ, bus.mostraB, bus.regErro, bus.zeraPontos, bus.regPontos,
            bus.mostraPontos, bus.serrou, bus.acertou, bus.db_timeout, bus.pronto};
  endfunction

  task automatic inicia(input logic [1:0] m);
    bus.modo  = m;
    bus.jogar = 1'b1;
    @(negedge clock);
    bus.jogar = 1'b0;
  endtask

  task automatic pulsaJogada(input int d, input logic certo);
    repeat (d) @(negedge clock);
    bus.botoesIgualMemoria = certo;
    bus.jogada = 1'b1;
    @(negedge clock);
    bus.jogada = 1'b0;
  endtask

  task automatic plano(input int e0, input int e1, input int e2);
    errs[0] = e0; errs[1] = e1; errs[2] = e2;
    for (int r = 0; r < N_RODADAS; r++)
      for (int k = 0; k < 4; k++) errPos[r][k] = $urandom_range(0, r);
  endtask

  // Game rules: each attempt shows the sequence (or only the newest element), the player
  // repeats it up to the failing position; errors end the game per mode and limit.
  task automatic modelo(input int modo);
    int erros;
    bit fim = 0;
    expMostra.delete(); expEspera.delete(); expRegErro.delete();
    expPontos.delete(); expErrState.delete(); expErrCount.delete();
    expFim = 'h0A;
    for (int r = 0; r < N_RODADAS && !fim; r++) begin
      bit rodadaOk = 0;
      int k = 0;
      erros = 0;
      while (!rodadaOk && !fim) begin
        if (modo == 2) expMostra.push_back(r);
        else for (int a = 0; a <= r; a++) expMostra.push_back(a);
        if (k < errs[r]) begin
          for (int a = 0; a <= errPos[r][k]; a++) expEspera.push_back(a);
          k++;
          erros = (erros < 7) ? erros + 1 : 7;
          expErrCount.push_back(erros);
          if (modo == 1 || (modo == 0 && erros >= MAX_ERROS)) begin
            fim = 1;
            expFim = 'h0F;
            expErrState.push_back('h0F);
          end else begin
            expErrState.push_back('h07);
          end
        end else begin
          for (int a = 0; a <= r; a++) expEspera.push_back(a);
          expRegErro.push_back(r * 16 + erros);
          rodadaOk = 1;
        end
      end
    end
    if (!fim) for (int a = 0; a < N_RODADAS; a++) expPontos.push_back(a);
  endtask

  task automatic jogaPartida(input logic [1:0] m, input string nome);
    bit ok, acabou = 0;
    modelo((m == 2'b11) ? 0 : int'(m));
    obsMostra.delete(); obsEspera.delete(); obsRegErro.delete(); obsPontos.delete();
    gravando = 1'b1;
    inicia(m);
    for (int r = 0; r < N_RODADAS && !acabou; r++) begin
      bit rodadaOk = 0;
      int k = 0;
      while (!rodadaOk && !acabou) begin
        bit errando = (k < errs[r]);
        int ultima  = errando ? errPos[r][k] : r;
        for (int pos = 0; pos <= ultima && !acabou; pos++) begin
          esperaAte(0, 200, {nome, "_espera"}, ok);
          if (!ok) acabou = 1;
          else pulsaJogada($urandom_range(0, 5), !(errando && pos == ultima));
        end
        if (acabou) break;
        if (errando) begin
          k++;
          esperaAte(1, 10, {nome, "_serrou"}, ok);
          @(negedge clock);
          verifica({nome, "_after_errou_state"}, bus.db_estado, expErrState.pop_front());
          verifica({nome, "_after_errou_erros"}, bus.erros_rodada, expErrCount.pop_front());
          if (bus.db_estado == 5'h0F) begin
            verifica({nome, "_strict_serrou_hold"}, bus.serrou, 1);
            acabou = 1;
          end else begin
            verifica({nome, "_serrou_one_cycle"}, bus.serrou, 0);
          end
        end else begin
          rodadaOk = 1;
        end
      end
    end
    esperaAte(2, 300, {nome, "_pronto"}, ok);
    verifica({nome, "_fim_estado"}, bus.db_estado, expFim);
    verifica({nome, "_acertou"}, bus.acertou, (expFim == 'h0A));
    verifica({nome, "_db_timeout"}, bus.db_timeout, 0);
    gravando = 1'b0;
    comparaFila({nome, "_mostra"}, obsMostra, expMostra);
    comparaFila({nome, "_espera_end"}, obsEspera, expEspera);
    comparaFila({nome, "_regErro"}, obsRegErro, expRegErro);
    comparaFila({nome, "_salva"}, obsPontos, expPontos);
  endtask

  initial begin
    bit ok;
    int n;
    bus.jogar = 1'b0;
    bus.modo = 2'b00;
    bus.botoesIgualMemoria = 1'b1;
    bus.jogada = 1'b0;

    repeat (2) @(negedge clock);
    verifica("reset_estado", bus.db_estado, 0);
    verifica("reset_saidas", saidas(), 0);
    verifica("reset_contadores", {bus.endereco, bus.rodada, bus.erros_rodada}, 0);
    reset = 1'b1;
    @(negedge clock);
    verifica("idle_estado", bus.db_estado, 0);

    plano(0, 0, 0);                          jogaPartida(2'b00, "classic_ok");
    plano(0, 1, 0);                          jogaPartida(2'b00, "classic_1err");
    plano(0, 2, 0);                          jogaPartida(2'b00, "classic_2err");
    plano(0, 0, 1);                          jogaPartida(2'b01, "strict_r2");
    plano($urandom_range(0, 1), 0, 0);       jogaPartida(2'b01, "strict_rand");
    plano(0, 0, 0);                          jogaPartida(2'b10, "newest_ok");
    plano($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    jogaPartida(2'b10, "newest_rand");
    plano($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    jogaPartida(2'b11, "mode3_rand");
    for (int g = 0; g < 3; g++) begin
      plano($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      jogaPartida(2'($urandom_range(0, 3)), "random");
    end

    // Play on the last allowed ESPERA cycle is accepted; on the timeout cycle it is not.
    inicia(2'b00);
    esperaAte(0, 200, "to_espera0", ok);
    pulsaJogada(TIMEOUT - 2, 1'b1);
    verifica("to_play_last_ok", bus.db_estado, 'h04);
    esperaAte(0, 200, "to_espera1", ok);
    pulsaJogada(TIMEOUT - 1, 1'b1);
    verifica("to_simultaneous_state", bus.db_estado, 'h0D);
    verifica("to_simultaneous_flag", bus.db_timeout, 1);

    inicia(2'b00);
    esperaAte(0, 200, "to_espera2", ok);
    n = 0;
    while (bus.db_estado == 5'h03 && n < 20) begin
      @(negedge clock);
      n++;
    end
    verifica("to_cycles_in_espera", n, TIMEOUT);
    verifica("to_idle_state", bus.db_estado, 'h0D);
    verifica("to_flags", {bus.db_timeout, bus.pronto, bus.acertou, bus.serrou}, 4'b1100);

    inicia(2'b00);
    esperaAte(0, 200, "rst_espera", ok);
    pulsaJogada(0, 1'b1);
    esperaAte(3, 200, "rst_mostra_r1", ok);
    #2 reset = 1'b0;
    #1;
    verifica("rst_async_estado", bus.db_estado, 0);
    verifica("rst_async_saidas", saidas(), 0);
    verifica("rst_async_contadores", {bus.endereco, bus.rodada, bus.erros_rodada}, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    verifica("rst_release_idle", bus.db_estado, 0);
    inicia(2'b00);
    esperaAte(4, 50, "rst_restart_mostra", ok);
    verifica("rst_restart_rodada", bus.rodada, 0);
    verifica("rst_restart_endereco", bus.endereco, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
